cu_read_command_arbiter_control: RTL and testbench
==================================================

CU_READ_COMMAND_ARBITER_CONTROL -- requirements
Module: cu_read_command_arbiter_control

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, per-requester queue depth in entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, maximum issued-but-unanswered read commands.
REQ-003 SHALL have parameter CMD_W, default 64, read command payload width in bits.
REQ-004 SHALL have port clock  in  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rstn_in  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enabled_in  in  1  level enable; low requests a drain.
REQ-007 SHALL have port req0_valid / req0_payload  in  1 / CMD_W  edge-job read command request.
REQ-008 SHALL have port req0_ready  out  1  queue 0 can accept.
REQ-009 SHALL have port req1_valid / req1_payload  in  1 / CMD_W  edge-data read command request.
REQ-010 SHALL have port req1_ready  out  1  queue 1 can accept.
REQ-011 SHALL have port read_buffer_full  in  1  downstream read command buffer full.
REQ-012 SHALL have port rsp_valid  in  1  one read response returned; frees one credit.
REQ-013 SHALL have port cmd_out_valid / cmd_out_payload / cmd_out_src  out  1 / CMD_W / 1  issued command and source queue (0 or 1).
REQ-014 SHALL have port outstanding_count  out  $clog2(MAX_OUTSTANDING+1)  issued commands awaiting response.
REQ-015 SHALL have port idle  out  1  high only in state DISABLED.
REQ-016 SHALL have port credit_underflow  out  1  sticky error flag.

Function
REQ-017 SHALL implement states DISABLED, RUN, DRAIN.
REQ-018 DISABLED -> RUN when enabled_in=1; RUN -> DRAIN when enabled_in=0; DRAIN -> DISABLED when both queues empty and outstanding_count=0; DRAIN -> RUN when enabled_in=1.
REQ-019 reqN_ready SHALL be 1 only in RUN with queue N count < FIFO_DEPTH, count taken from the register (no pass-through on simultaneous pop).
REQ-020 Accepted request (valid & ready) SHALL be written to queue N on that edge, preserving order per queue.
REQ-021 Issue condition: state RUN or DRAIN, read_buffer_full=0, outstanding_count < MAX_OUTSTANDING, at least one queue non-empty.
REQ-022 Issue SHALL pop exactly one entry per cycle; cmd_out_valid is a registered single-cycle pulse per issued command; payload/src registered with it.
REQ-023 Both queues non-empty: SHALL grant the queue not granted last (round-robin); last-grant register resets to 1 so queue 0 wins first.
REQ-024 One queue non-empty: SHALL grant it regardless of last grant and update last grant.
REQ-025 Latency: request accepted at edge E, with issue conditions met, SHALL give cmd_out_valid=1 in the cycle following edge E+1.
REQ-026 outstanding_count SHALL +1 on issue, -1 on rsp_valid, unchanged when both occur in one cycle.
REQ-027 rsp_valid with outstanding_count=0 and no issue that cycle SHALL leave count at 0 and set credit_underflow until reset.
REQ-028 cmd_out_valid SHALL be 0 whenever the issue condition is false; cmd_out_payload holds its last value.
REQ-029 read_buffer_full sampled at edge of issue decision; no command issued in a cycle where it is 1.
REQ-030 Queue pointers SHALL wrap modulo FIFO_DEPTH; counts never exceed FIFO_DEPTH.

Reset
REQ-031 On rstn_in low, asynchronously: state DISABLED, queues empty, outstanding_count 0, cmd_out_valid 0, cmd_out_payload 0, cmd_out_src 0, req0_ready 0, req1_ready 0, idle 1, credit_underflow 0, last grant 1.
REQ-032 Reset mid-operation SHALL discard queued and outstanding state; responses arriving after release are treated per REQ-027.
REQ-033 First accept possible on the edge after enabled_in=1 is sampled (RUN entry).

Verification
REQ-034 Enable, req0 payload 0xA1 and req1 payload 0xB2 same cycle -> cmd_out 0xA1 src 0 then 0xB2 src 1 on consecutive cycles, outstanding_count 2.
REQ-035 MAX_OUTSTANDING=16, 20 req0 commands, no responses -> exactly 16 issued, count 16; one rsp_valid -> one more issued, count stays 16.
REQ-036 Queue 0 filled with 4 entries, read_buffer_full=1 -> req0_ready=0, no cmd_out_valid; release full -> 4 issues in 4 cycles in write order.
REQ-037 Issue and rsp_valid in same cycle with count 5 -> count remains 5; rsp_valid with count 0 -> count 0, credit_underflow=1.
REQ-038 enabled_in dropped with 2 queued, 3 outstanding -> readies 0, 2 issues, idle=1 only after 5 rsp_valid pulses.
REQ-039 rstn_in asserted with 3 queued, 4 outstanding -> all outputs at REQ-031 values immediately; no cmd_out_valid after release until new requests.

Source files
------------

// File: rtl/cu_read_command_arbiter_control.sv
// Read command arbiter for the compute unit: two request queues (edge-job and
// edge-data), round-robin issue towards the read command buffer, and a
// credit counter bounding how many reads may be in flight at once.
module cu_read_command_arbiter_control #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CMD_W           = 64
) (
  input  logic                                   clock,
  input  logic                                   rstn_in,
  input  logic                                   enabled_in,
  input  logic                                   req0_valid,
  input  logic [CMD_W-1:0]                       req0_payload,
  output logic                                   req0_ready,
  input  logic                                   req1_valid,
  input  logic [CMD_W-1:0]                       req1_payload,
  output logic                                   req1_ready,
  input  logic                                   read_buffer_full,
  input  logic                                   rsp_valid,
  output logic                                   cmd_out_valid,
  output logic [CMD_W-1:0]                       cmd_out_payload,
  output logic                                   cmd_out_src,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_count,
  output logic                                   idle,
  output logic                                   credit_underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUTSTANDING);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  logic [1:0]       r_state, w_state_nxt;
  logic [OW-1:0]    r_outstanding;
  logic             r_last;
  logic             r_cmd_valid, r_cmd_src, r_underflow;
  logic [CMD_W-1:0] r_cmd_payload;

  logic [1:0]            w_valid, w_ready, w_push, w_pop, w_nonempty;
  logic [1:0][CMD_W-1:0] w_wdata, w_head;
  logic                  w_active, w_issue, w_grant;

  assign w_valid = {req1_valid, req0_valid};
  assign w_wdata = {req1_payload, req0_payload};
  assign w_push  = w_valid & w_ready;

  // Two identical circular queues; depth is a power of two so pointers wrap for free.
  for (genvar g = 0; g < 2; g++) begin : g_q
    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy bookkeeping; push and pop together leave the count alone.
    always_ff @(posedge clock or negedge rstn_in) begin
      if (!rstn_in) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PW'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PW'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage needs no reset: the zeroed count marks every slot as empty.
    always_ff @(posedge clock) begin
      if (w_push[g]) r_mem[r_wptr] <= w_wdata[g];
    end

    assign w_head[g]     = r_mem[r_rptr];
    assign w_nonempty[g] = (r_count != '0);
    // Ready comes from the registered count only, so a full queue stays
    // closed even in a cycle where it is being popped.
    assign w_ready[g]    = (r_state == ST_RUN) && (r_count < DEPTH_C);
  end

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_issue  = w_active && !read_buffer_full && (r_outstanding < MAX_C) && (|w_nonempty);
  // Both waiting: alternate away from the last winner. Otherwise take whoever has work.
  assign w_grant  = (&w_nonempty) ? ~r_last : ~w_nonempty[0];
  assign w_pop    = {w_issue & w_grant, w_issue & ~w_grant};

  // Registered issue pulse; payload and source hold between issues.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_payload <= '0;
      r_cmd_src     <= 1'b0;
      r_last        <= 1'b1;
    end else begin
      r_cmd_valid <= w_issue;
      if (w_issue) begin
        r_cmd_payload <= w_head[w_grant];
        r_cmd_src     <= w_grant;
        r_last        <= w_grant;
      end
    end
  end

  // Credit tracking: a response with nothing in flight is clamped and flagged.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      r_outstanding <= '0;
      r_underflow   <= 1'b0;
    end else begin
      case ({w_issue, rsp_valid})
        2'b10: r_outstanding <= r_outstanding + OW'(1);
        2'b01: begin
          if (r_outstanding != '0) r_outstanding <= r_outstanding - OW'(1);
          else                     r_underflow   <= 1'b1;
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Control FSM next state: re-enable beats the drain-complete exit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISABLED: if (enabled_in) w_state_nxt = ST_RUN;
      ST_RUN:      if (!enabled_in) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enabled_in)
          w_state_nxt = ST_RUN;
        else if (!(|w_nonempty) && (r_outstanding == '0))
          w_state_nxt = ST_DISABLED;
      end
      default:     w_state_nxt = ST_DISABLED;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) r_state <= ST_DISABLED;
    else          r_state <= w_state_nxt;
  end

  assign req0_ready        = w_ready[0];
  assign req1_ready        = w_ready[1];
  assign cmd_out_valid     = r_cmd_valid;
  assign cmd_out_payload   = r_cmd_payload;
  assign cmd_out_src       = r_cmd_src;
  assign outstanding_count = r_outstanding;
  assign idle              = (r_state == ST_DISABLED);
  assign credit_underflow  = r_underflow;

endmodule

// File: tb/tb_cu_read_command_arbiter_control.sv
// Directed bench for the read command arbiter. A queue-based behavioural model
// predicts every output each cycle; literal checks pin the key scenarios.
module tb_cu_read_command_arbiter_control;
  localparam int FD = 4;
  localparam int MO = 16;
  localparam int CW = 64;

  logic          clock = 1'b0;
  logic          rstn_in = 1'b0;
  logic          enabled_in = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [CW-1:0] req0_payload = '0, req1_payload = '0;
  logic          read_buffer_full = 1'b0, rsp_valid = 1'b0;
  logic          req0_ready, req1_ready, cmd_out_valid, cmd_out_src, idle, credit_underflow;
  logic [CW-1:0] cmd_out_payload;
  logic [4:0]    outstanding_count;

  cu_read_command_arbiter_control #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .CMD_W(CW)) dut (
    .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in),
    .req0_valid(req0_valid), .req0_payload(req0_payload), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_payload(req1_payload), .req1_ready(req1_ready),
    .read_buffer_full(read_buffer_full), .rsp_valid(rsp_valid),
    .cmd_out_valid(cmd_out_valid), .cmd_out_payload(cmd_out_payload), .cmd_out_src(cmd_out_src),
    .outstanding_count(outstanding_count), .idle(idle), .credit_underflow(credit_underflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;
  int n_issued = 0;

  // Behavioural model: mode 0=off, 1=accepting, 2=finishing up.
  logic [CW-1:0] q0[$];
  logic [CW-1:0] q1[$];
  int            m_mode, m_out;
  bit            m_last, m_uf, m_vld, m_src, m_acc0, m_acc1;
  logic [CW-1:0] m_pay;

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_mode = 0; m_out = 0; m_last = 1'b1; m_uf = 1'b0;
    m_vld = 1'b0; m_src = 1'b0; m_pay = '0; m_acc0 = 1'b0; m_acc1 = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("cmp_valid",  cmd_out_valid, m_vld);
    chk("cmp_payload", cmd_out_payload, m_pay);
    chk("cmp_src",    cmd_out_src, m_src);
    chk("cmp_outstanding", outstanding_count, m_out);
    chk("cmp_idle",   idle, m_mode == 0);
    chk("cmp_underflow", credit_underflow, m_uf);
    chk("cmp_ready0", req0_ready, (m_mode == 1) && (q0.size() < FD));
    chk("cmp_ready1", req1_ready, (m_mode == 1) && (q1.size() < FD));
  endtask

  // Advance model and DUT by one edge, then compare everything.
  task automatic tick();
    int  s0, s1, out_pre;
    bit  can, pick, empty_pre;
    s0 = q0.size(); s1 = q1.size(); out_pre = m_out;
    empty_pre = (s0 == 0) && (s1 == 0);
    m_acc0 = req0_valid && (m_mode == 1) && (s0 < FD);
    m_acc1 = req1_valid && (m_mode == 1) && (s1 < FD);
    can = (m_mode != 0) && !read_buffer_full && (m_out < MO) && !empty_pre;
    if (can) begin
      pick = (s0 > 0 && s1 > 0) ? !m_last : (s0 == 0);
      if (pick) m_pay = q1.pop_front();
      else      m_pay = q0.pop_front();
      m_src = pick; m_last = pick; m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
    if (m_acc0) q0.push_back(req0_payload);
    if (m_acc1) q1.push_back(req1_payload);
    if (can && !rsp_valid) m_out = m_out + 1;
    else if (!can && rsp_valid) begin
      if (m_out == 0) m_uf = 1'b1;
      else            m_out = m_out - 1;
    end
    case (m_mode)
      0: if (enabled_in) m_mode = 1;
      1: if (!enabled_in) m_mode = 2;
      default: begin
        if (enabled_in) m_mode = 1;
        else if (empty_pre && out_pre == 0) m_mode = 0;
      end
    endcase
    @(posedge clock); #1;
    if (cmd_out_valid) n_issued++;
    compare_all();
  endtask

  task automatic push_n(input int qsel, input int n, input logic [63:0] base);
    int i = 0;
    for (int c = 0; c < 100 && i < n; c++) begin
      if (qsel == 0) begin req0_valid = 1'b1; req0_payload = base + 64'(i); end
      else           begin req1_valid = 1'b1; req1_payload = base + 64'(i); end
      tick();
      if ((qsel == 0 && m_acc0) || (qsel == 1 && m_acc1)) i++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("push_done", i, n);
  endtask

  // Return responses until nothing is queued or in flight.
  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      if (q0.size() == 0 && q1.size() == 0 && m_out == 0) break;
      rsp_valid = (m_out > 0);
      tick();
    end
    rsp_valid = 1'b0;
    chk("drain_outstanding", outstanding_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #3;
    chk("rst_idle", idle, 1);
    chk("rst_valid", cmd_out_valid, 0);
    chk("rst_payload", cmd_out_payload, 0);
    chk("rst_src", cmd_out_src, 0);
    chk("rst_outstanding", outstanding_count, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_underflow", credit_underflow, 0);
    @(posedge clock); @(posedge clock); #1;
    rstn_in = 1'b1;

    // Same-cycle requests on both queues: queue 0 first, then queue 1.
    enabled_in = 1'b1;
    tick();
    chk("run_ready0", req0_ready, 1);
    req0_valid = 1'b1; req0_payload = 64'hA1;
    req1_valid = 1'b1; req1_payload = 64'hB2;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("lat_no_early_valid", cmd_out_valid, 0);
    tick();
    chk("rr_first_valid", cmd_out_valid, 1);
    chk("rr_first_payload", cmd_out_payload, 64'hA1);
    chk("rr_first_src", cmd_out_src, 0);
    tick();
    chk("rr_second_valid", cmd_out_valid, 1);
    chk("rr_second_payload", cmd_out_payload, 64'hB2);
    chk("rr_second_src", cmd_out_src, 1);
    chk("rr_outstanding", outstanding_count, 2);
    tick();
    chk("rr_pulse_ends", cmd_out_valid, 0);
    drain();

    // Credit limit: 20 commands, only 16 may be in flight.
    n_issued = 0;
    push_n(0, 20, 64'h100);
    repeat (10) tick();
    chk("cap_issued", n_issued, 16);
    chk("cap_outstanding", outstanding_count, 16);
    chk("cap_ready0_full", req0_ready, 0);
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    tick();
    chk("cap_refill_issued", n_issued, 17);
    chk("cap_refill_outstanding", outstanding_count, 16);
    drain();
    chk("cap_all_issued", n_issued, 20);

    // Downstream full: queue fills, nothing issues, then 4 back-to-back in order.
    read_buffer_full = 1'b1;
    n_issued = 0;
    push_n(0, 4, 64'hC0);
    chk("full_ready0", req0_ready, 0);
    chk("full_no_issue", n_issued, 0);
    read_buffer_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("full_release_valid", cmd_out_valid, 1);
      chk("full_release_order", cmd_out_payload, 64'hC0 + 64'(k));
    end
    drain();

    // Issue and response together, then a response with nothing in flight.
    push_n(0, 5, 64'h50);
    repeat (4) tick();
    chk("both_pre_count", outstanding_count, 5);
    read_buffer_full = 1'b1;
    push_n(0, 1, 64'h55);
    read_buffer_full = 1'b0;
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    chk("both_valid", cmd_out_valid, 1);
    chk("both_payload", cmd_out_payload, 64'h55);
    chk("both_count_held", outstanding_count, 5);
    drain();
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    chk("uf_count_zero", outstanding_count, 0);
    chk("uf_flag", credit_underflow, 1);

    // Disable with 2 queued and 3 in flight.
    push_n(0, 3, 64'h30);
    repeat (3) tick();
    chk("drain_pre_count", outstanding_count, 3);
    read_buffer_full = 1'b1;
    push_n(0, 1, 64'h40);
    push_n(1, 1, 64'h41);
    read_buffer_full = 1'b0;
    enabled_in = 1'b0;
    tick();
    chk("drain_ready0", req0_ready, 0);
    chk("drain_ready1", req1_ready, 0);
    repeat (2) tick();
    chk("drain_count5", outstanding_count, 5);
    for (int k = 0; k < 5; k++) begin
      rsp_valid = 1'b1; tick();
      chk("drain_not_idle", idle, 0);
    end
    rsp_valid = 1'b0;
    tick();
    chk("drain_idle", idle, 1);

    // Asynchronous reset mid-operation.
    enabled_in = 1'b1;
    tick();
    push_n(0, 4, 64'h60);
    repeat (3) tick();
    chk("arst_pre_count", outstanding_count, 4);
    read_buffer_full = 1'b1;
    push_n(0, 3, 64'h70);
    #2 rstn_in = 1'b0;
    model_reset();
    #1;
    chk("arst_idle", idle, 1);
    chk("arst_valid", cmd_out_valid, 0);
    chk("arst_payload", cmd_out_payload, 0);
    chk("arst_src", cmd_out_src, 0);
    chk("arst_outstanding", outstanding_count, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_ready1", req1_ready, 0);
    chk("arst_underflow", credit_underflow, 0);
    @(posedge clock); @(posedge clock); #1;
    rstn_in = 1'b1;
    read_buffer_full = 1'b0;
    n_issued = 0;
    repeat (5) tick();
    chk("arst_no_issue", n_issued, 0);
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    chk("arst_late_rsp_count", outstanding_count, 0);
    chk("arst_late_rsp_uf", credit_underflow, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
